uart_fifo: RTL and testbench

Parametrised, buffered UART: a full-duplex serial port with compile-time data width, parity and stop-bit settings, a transmit FIFO and a receive FIFO, and sticky line-error flags. It replaces the unbuffered one-byte UART at the top of the serial path. Software-side logic pushes and pops words at its own pace, and the block handles framing on the `rx`/`tx` pins.

---
 rtl/uart_fifo.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered full-duplex UART with TX/RX FIFOs and sticky line-error flags
module uart_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_AW      = 4
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_wr_en,
  input  logic [DATA_BITS-1:0] tx_wr_data,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [FIFO_AW:0]     tx_count,
  input  logic                 rx_rd_en,
  output logic [DATA_BITS-1:0] rx_rd_data,
  output logic                 rx_empty,
  output logic [FIFO_AW:0]     rx_count,
  input  logic                 err_clr,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [PW-1:0]        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [DATA_BITS-1:0] tx_mem_q [DEPTH];
  state_t               tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_stop_q, tx_stop_d, tx_par_q, tx_par_d;
  logic                 tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic                 tx_push, tx_pop, tx_full_w, tx_empty_w, tx_bit_done;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [PW-1:0]        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [DATA_BITS-1:0] rx_mem_q [DEPTH];
  state_t               rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_rd_data_q, rx_rd_data_d;
  logic                 rx_stop_q, rx_stop_d, rx_pbit_q, rx_pbit_d, rx_fbad_q, rx_fbad_d;
  logic                 rx_push, rx_pop, rx_full_w, rx_empty_w, rx_par_bad;
  logic                 parity_set, frame_set, overrun_set;
  logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d, overrun_q, overrun_d;

  assign tx_full_w  = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                      (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
  assign tx_empty_w = (tx_wptr_q == tx_rptr_q);
  assign rx_full_w  = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                      (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);
  assign rx_empty_w = (rx_wptr_q == rx_rptr_q);

  // TX FIFO bookkeeping and transmit framer: start, data LSB first, optional parity, stop bits
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_stop_d   = tx_stop_q;
    tx_par_d    = tx_par_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    tx_pop      = 1'b0;
    tx_push     = tx_wr_en && !tx_full_w;
    tx_bit_done = (tx_cnt_q == CNT_LAST);
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_done ? '0 : tx_cnt_q + CW'(1);
    case (tx_state_q)
      S_IDLE: if (!tx_empty_w) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_mem_q[tx_rptr_q[FIFO_AW-1:0]];
        tx_par_d   = (PARITY == 1) ? ~(^tx_mem_q[tx_rptr_q[FIFO_AW-1:0]])
                                   : (^tx_mem_q[tx_rptr_q[FIFO_AW-1:0]]);
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_d       = 1'b0;
        tx_busy_d  = 1'b1;
      end
      S_START: if (tx_bit_done) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end
      S_DATA: if (tx_bit_done) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_stop_d  = 1'b0;
          tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_d       = tx_shift_q[1];
        end
      end
      S_PARITY: if (tx_bit_done) begin
        tx_state_d = S_STOP;
        tx_d       = 1'b1;
      end
      S_STOP: if (tx_bit_done) begin
        if (tx_stop_q == STOP_LAST) begin
          tx_state_d = S_IDLE;
          tx_busy_d  = 1'b0;
        end else begin
          tx_stop_d = 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    tx_wptr_d = tx_wptr_q + PW'(tx_push);
    tx_rptr_d = tx_rptr_q + PW'(tx_pop);
  end

  // Receive framer: mid-bit sampling after a synchronised falling edge, end-of-frame checks, RX FIFO, sticky flags
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_stop_d   = rx_stop_q;
    rx_pbit_d   = rx_pbit_q;
    rx_fbad_d   = rx_fbad_q;
    rx_push     = 1'b0;
    parity_set  = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    rx_par_bad  = (PARITY == 0) ? 1'b0 : ((^rx_shift_q ^ rx_pbit_q) != (PARITY == 1));
    case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_DATA: if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) begin
          rx_stop_d  = 1'b0;
          rx_fbad_d  = 1'b0;
          rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_PARITY: if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_d   = '0;
        rx_pbit_d  = rx_s2_q;
        rx_state_d = S_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      S_STOP: if (rx_cnt_q == CNT_LAST) begin
        rx_cnt_d = '0;
        if (rx_stop_q == STOP_LAST) begin
          rx_state_d = S_IDLE;
          if (rx_fbad_q || !rx_s2_q) frame_set = 1'b1;
          else if (rx_par_bad)       parity_set = 1'b1;
          else if (rx_full_w)        overrun_set = 1'b1;
          else                       rx_push = 1'b1;
        end else begin
          rx_stop_d = 1'b1;
          rx_fbad_d = !rx_s2_q;
        end
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_state_d = S_IDLE;
    endcase
    rx_pop    = rx_rd_en && !rx_empty_w;
    rx_wptr_d = rx_wptr_q + PW'(rx_push);
    rx_rptr_d = rx_rptr_q + PW'(rx_pop);
    // Head register tracks the post-update head; a word landing in an empty FIFO bypasses memory.
    rx_rd_data_d = rx_rd_data_q;
    if (rx_wptr_d != rx_rptr_d) begin
      if (rx_push && (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_d[FIFO_AW-1:0])) rx_rd_data_d = rx_shift_q;
      else rx_rd_data_d = rx_mem_q[rx_rptr_d[FIFO_AW-1:0]];
    end
    parity_err_d = (parity_err_q && !err_clr) || parity_set;
    frame_err_d  = (frame_err_q && !err_clr) || frame_set;
    overrun_d    = (overrun_q && !err_clr) || overrun_set;
  end

  // FIFO storage arrays; contents are only read behind valid pointers so they need no reset
  always_ff @(posedge clk_100MHz) begin
    if (tx_push) tx_mem_q[tx_wptr_q[FIFO_AW-1:0]] <= tx_wr_data;
    if (rx_push) rx_mem_q[rx_wptr_q[FIFO_AW-1:0]] <= rx_shift_q;
  end

  // State registers; reset drives the line idle-high at once and aborts any frame in flight
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      tx_wptr_q <= '0;  tx_rptr_q <= '0;  tx_state_q <= S_IDLE;  tx_cnt_q <= '0;
      tx_bit_q <= '0;   tx_shift_q <= '0; tx_stop_q <= 1'b0;     tx_par_q <= 1'b0;
      tx_q <= 1'b1;     tx_busy_q <= 1'b0;
      rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
      rx_wptr_q <= '0;  rx_rptr_q <= '0;  rx_state_q <= S_IDLE;  rx_cnt_q <= '0;
      rx_bit_q <= '0;   rx_shift_q <= '0; rx_stop_q <= 1'b0;     rx_pbit_q <= 1'b0;
      rx_fbad_q <= 1'b0; rx_rd_data_q <= '0;
      parity_err_q <= 1'b0; frame_err_q <= 1'b0; overrun_q <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;  tx_rptr_q <= tx_rptr_d;  tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;    tx_shift_q <= tx_shift_d; tx_stop_q <= tx_stop_d;   tx_par_q <= tx_par_d;
      tx_q <= tx_d;            tx_busy_q <= tx_busy_d;
      rx_s1_q <= rx;           rx_s2_q <= rx_s1_q;       rx_prev_q <= rx_s2_q;
      rx_wptr_q <= rx_wptr_d;  rx_rptr_q <= rx_rptr_d;  rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;    rx_shift_q <= rx_shift_d; rx_stop_q <= rx_stop_d;   rx_pbit_q <= rx_pbit_d;
      rx_fbad_q <= rx_fbad_d;  rx_rd_data_q <= rx_rd_data_d;
      parity_err_q <= parity_err_d; frame_err_q <= frame_err_d; overrun_q <= overrun_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign tx_full    = tx_full_w;
  assign tx_count   = tx_wptr_q - tx_rptr_q;
  assign rx_rd_data = rx_rd_data_q;
  assign rx_empty   = rx_empty_w;
  assign rx_count   = rx_wptr_q - rx_rptr_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized self-checking bench for uart_fifo against a queue-based model
`timescale 1ns/1ps
module tb_uart_fifo;
  localparam int CPB = 16, DB = 8, PAR = 2, SB = 1, AW = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = (1 + DB + 1 + SB) * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loopback = 1'b0;
  logic rx_w, tx_w;
  logic tx_wr_en = 1'b0;
  logic [7:0] tx_wr_data = 8'h00;
  logic tx_full, tx_busy;
  logic [AW:0] tx_count, rx_count;
  logic rx_rd_en = 1'b0;
  logic [7:0] rx_rd_data;
  logic rx_empty;
  logic err_clr = 1'b0;
  logic parity_err, frame_err, overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

  int run_len = 0;
  logic busy_prev = 1'b0;
  int busy_runs[$];
  int gap_runs[$];

  always #5 clk = ~clk;
  assign rx_w = loopback ? tx_w : rx_drv;

  uart_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_AW(AW)) dut (
    .clk_100MHz(clk), .reset(rst_n), .rx(rx_w), .tx(tx_w),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_busy(tx_busy),
    .tx_count(tx_count), .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .rx_count(rx_count), .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun)
  );

  // Run lengths of tx_busy high (frame length) and low (inter-frame gap)
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len <= 0;
      busy_prev <= 1'b0;
    end else begin
      if (tx_busy == busy_prev) run_len <= run_len + 1;
      else begin
        if (busy_prev) busy_runs.push_back(run_len);
        else gap_runs.push_back(run_len);
        run_len <= 1;
      end
      busy_prev <= tx_busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v, input bit release_line);
    logic [10:0] bits;
    logic pbit;
    pbit = (($countones(d) % 2) == 1) ^ bad_par;
    bits = {stop_v, pbit, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      wait_cycles(CPB);
    end
    if (release_line) begin
      rx_drv = 1'b1;
      wait_cycles(4);
    end
  endtask

  task automatic apply_frame(input logic [7:0] d, input bit bad_par, input bit stop_v);
    if (!stop_v) m_fe = 1'b1;
    else if (bad_par) m_pe = 1'b1;
    else if (rxq.size() == DEPTH) m_ov = 1'b1;
    else rxq.push_back(d);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_pe"}, parity_err, m_pe);
    chk({tag, "_fe"}, frame_err, m_fe);
    chk({tag, "_ov"}, overrun, m_ov);
    chk({tag, "_cnt"}, rx_count, rxq.size());
    chk({tag, "_empty"}, rx_empty, rxq.size() == 0);
  endtask

  task automatic pop_check(input string tag);
    chk(tag, rx_rd_data, rxq[0]);
    rx_rd_en = 1'b1;
    step();
    rx_rd_en = 1'b0;
    void'(rxq.pop_front());
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    chk("clr_flags", {parity_err, frame_err, overrun}, 3'b000);
  endtask

  task automatic wait_tx_idle();
    int t;
    t = 0;
    wait_cycles(2);
    while ((tx_busy || tx_count != 0) && t < 6 * FRAME) begin step(); t++; end
    chk("tx_idle_bound", t < 6 * FRAME, 1);
  endtask

  task automatic decode_tx(output logic [7:0] d, output bit got);
    int t;
    logic [7:0] v;
    logic p;
    d = 8'h00;
    got = 1'b0;
    v = 8'h00;
    t = 0;
    while (tx_busy && t < 2 * FRAME) begin step(); t++; end
    t = 0;
    while (tx_w && t < 2 * FRAME) begin step(); t++; end
    if (tx_w) return;
    got = 1'b1;
    wait_cycles(CPB / 2);
    chk("tx_start", tx_w, 0);
    for (int i = 0; i < DB; i++) begin
      wait_cycles(CPB);
      v[i] = tx_w;
    end
    wait_cycles(CPB);
    p = tx_w;
    chk("tx_parity", ($countones(v) + p) % 2, 0);
    wait_cycles(CPB);
    chk("tx_stop", tx_w, 1);
    d = v;
  endtask

  initial begin
    logic [7:0] d;
    bit got;
    int n, lows;

    wait_cycles(3);
    chk("rst_tx", tx_w, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_txcnt", tx_count, 0);
    chk("rst_empty", rx_empty, 1);
    chk("rst_rxcnt", rx_count, 0);
    chk("rst_rdata", rx_rd_data, 0);
    chk("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    rst_n = 1'b1;
    step();

    // Directed loopback: A5, 3C, FF
    loopback = 1'b1;
    busy_runs.delete();
    gap_runs.delete();
    tx_wr_en = 1'b1; tx_wr_data = 8'hA5; rxq.push_back(8'hA5);
    step();
    chk("lb_tx_still_idle", tx_w, 1);
    chk("lb_cnt1", tx_count, 1);
    tx_wr_data = 8'h3C; rxq.push_back(8'h3C);
    step();
    chk("lb_tx_start", tx_w, 0);
    chk("lb_busy_start", tx_busy, 1);
    chk("lb_cnt_after_pop", tx_count, 1);
    tx_wr_data = 8'hFF; rxq.push_back(8'hFF);
    step();
    tx_wr_en = 1'b0;
    wait_tx_idle();
    wait_cycles(30);
    chk("lb_busy_runs", busy_runs.size(), 3);
    for (int i = 0; i < 3; i++) chk("lb_frame_len", (busy_runs.size() > i) ? busy_runs[i] : -1, FRAME);
    chk("lb_gap_runs", gap_runs.size(), 3);
    for (int i = 1; i < 3; i++) chk("lb_gap_len", (gap_runs.size() > i) ? gap_runs[i] : -1, 1);
    chk("lb_rxcnt", rx_count, 3);
    while (rxq.size() > 0) pop_check("lb_pop");
    chk("lb_empty", rx_empty, 1);

    // Randomized loopback batches
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        tx_wr_en = 1'b1;
        tx_wr_data = 8'($urandom);
        rxq.push_back(tx_wr_data);
        step();
      end
      tx_wr_en = 1'b0;
      wait_tx_idle();
      wait_cycles(30);
      check_rx("rlb");
      while (rxq.size() > 0) pop_check("rlb_pop");
    end

    // TX FIFO fill while the engine is busy: the 5th write is dropped
    loopback = 1'b0;
    rx_drv = 1'b1;
    tx_wr_en = 1'b1; tx_wr_data = 8'($urandom);
    step();
    tx_wr_en = 1'b0;
    wait_cycles(3);
    for (int i = 1; i <= 5; i++) begin
      tx_wr_en = 1'b1;
      tx_wr_data = 8'($urandom);
      if (i <= DEPTH) txq.push_back(tx_wr_data);
      step();
      chk("fill_cnt", tx_count, (i < DEPTH) ? i : DEPTH);
      chk("fill_full", tx_full, i >= DEPTH);
    end
    tx_wr_en = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      decode_tx(d, got);
      chk("fill_frame_seen", got, 1);
      chk("fill_frame_data", d, txq.pop_front());
      chk("fill_cnt_drain", tx_count, DEPTH - i);
      chk("fill_full_drain", tx_full, 0);
    end
    wait_cycles(20);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!tx_w) lows++;
    end
    chk("fill_no_extra_frame", lows, 0);
    chk("fill_busy_end", tx_busy, 0);

    // Parity error
    send_frame(8'h55, 1'b1, 1'b1, 1'b1);
    apply_frame(8'h55, 1'b1, 1'b1);
    check_rx("perr");
    clear_errs();

    // Framing error followed by a line held low
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    apply_frame(8'h81, 1'b0, 1'b0);
    check_rx("ferr");
    clear_errs();
    wait_cycles(200);
    check_rx("ferr_hold_low");
    rx_drv = 1'b1;
    wait_cycles(10);

    // Overrun: five frames into a four-word FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 1'b1);
      apply_frame(8'(i), 1'b0, 1'b1);
    end
    check_rx("ovr");
    for (int i = 1; i <= DEPTH; i++) begin
      chk("ovr_order", rxq[0], i);
      pop_check("ovr_pop");
    end
    chk("ovr_empty", rx_empty, 1);
    clear_errs();

    // Randomized frames with injected line errors, random pops and clears
    for (int f = 0; f < 16; f++) begin
      int r;
      logic [7:0] rd;
      bit bp, bs;
      r = $urandom_range(0, 5);
      rd = 8'($urandom);
      bp = (r == 1);
      bs = (r != 0);
      send_frame(rd, bp, bs, 1'b1);
      apply_frame(rd, bp, bs);
      check_rx("rnd");
      if (rxq.size() > 0 && $urandom_range(0, 2) != 0) pop_check("rnd_pop");
      if ($urandom_range(0, 3) == 0) clear_errs();
    end
    while (rxq.size() > 0) pop_check("rnd_drain");
    clear_errs();

    // Short low glitch is rejected by the start re-sample
    rx_drv = 1'b0;
    wait_cycles(4);
    rx_drv = 1'b1;
    wait_cycles(60);
    check_rx("glitch");

    // Reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      tx_wr_en = 1'b1;
      tx_wr_data = 8'($urandom);
      step();
    end
    tx_wr_en = 1'b0;
    wait_cycles(50);
    chk("mid_busy", tx_busy, 1);
    chk("mid_cnt", tx_count, 2);
    rst_n = 1'b0;
    #1;
    chk("areset_tx", tx_w, 1);
    chk("areset_cnt", tx_count, 0);
    chk("areset_busy", tx_busy, 0);
    chk("areset_empty", rx_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
